// File: rtl/ram_ctrl_param_if.sv
// MOV/MOC request bus between the control unit and the parametrised RAM.
// The master drives the request; the slave (the RAM) returns data and status.
interface ram_ctrl_param_if;
    logic        MOV;
    logic        ReadWrite;
    logic [2:0]  MS_2_0;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        ERR;

    modport master (
        output MOV,
        output ReadWrite,
        output MS_2_0,
        output Address,
        output DataIn,
        input  DataOut,
        input  MOC,
        input  ERR
    );

    modport slave (
        input  MOV,
        input  ReadWrite,
        input  MS_2_0,
        input  Address,
        input  DataIn,
        output DataOut,
        output MOC,
        output ERR
    );
endinterface

// File: rtl/ram_ctrl_param.sv
// Byte-addressed big-endian RAM with MOV/MOC handshake, configurable depth and wait states,
// byte/halfword/word access with sign control, and error reporting for bad requests.
module ram_ctrl_param #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    ram_ctrl_param_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] dout_q, dout_d;
    logic [2:0]  ms_q, ms_d;
    logic        rw_q, rw_d;
    logic        err_q, err_d;

    logic [7:0]  memory [Depth];

    logic        is_byte, is_half, is_word, size_ok, range_err, req_err;
    idx_t        a0, a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  wd0, wd1, wd2, wd3;
    logic [31:0] load_data;
    logic        access, we;

    // Request decode, always on the latched copy so inputs may change after acceptance.
    always_comb begin
        is_byte   = (ms_q[1:0] == 2'b00);
        is_half   = (ms_q[1:0] == 2'b01);
        is_word   = (ms_q == 3'b010);
        size_ok   = is_byte | is_half | is_word;
        range_err = ((addr_q >> ADDR_WIDTH) != 32'd0);
        req_err   = !size_ok
                  | (is_half & addr_q[0])
                  | (is_word & (addr_q[1:0] != 2'b00))
                  | range_err;
    end

    // Aligned accesses never carry into the low bits, so OR forms the lane addresses.
    always_comb begin
        a0 = addr_q[ADDR_WIDTH-1:0];
        a1 = a0 | idx_t'(1);
        a2 = a0 | idx_t'(2);
        a3 = a0 | idx_t'(3);
        b0 = memory[a0];
        b1 = memory[a1];
        b2 = memory[a2];
        b3 = memory[a3];
    end

    always_comb begin
        if (is_word) begin
            load_data = {b0, b1, b2, b3};
        end else if (is_half) begin
            load_data = {{16{ms_q[2] & b0[7]}}, b0, b1};
        end else begin
            load_data = {{24{ms_q[2] & b0[7]}}, b0};
        end
    end

    always_comb begin
        wd0 = is_word ? din_q[31:24] : (is_half ? din_q[15:8] : din_q[7:0]);
        wd1 = is_word ? din_q[23:16] : din_q[7:0];
        wd2 = din_q[15:8];
        wd3 = din_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ms_d    = ms_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        err_d   = err_q;
        access  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.MOV) begin
                    addr_d  = bus.Address;
                    din_d   = bus.DataIn;
                    ms_d    = bus.MS_2_0;
                    rw_d    = bus.ReadWrite;
                    cnt_d   = 4'(WAIT_STATES);
                    // With zero wait states this single pass is the latch-to-access stage.
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    err_d   = req_err;
                    state_d = StDone;
                    if (!req_err && rw_q) begin
                        dout_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (!bus.MOV) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            ms_q    <= 3'd0;
            rw_q    <= 1'b0;
            dout_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ms_q    <= ms_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset; a reset landing on the access edge must suppress the write.
    assign we = access & ~req_err & ~rw_q & RESET;

    always_ff @(posedge CLK) begin
        if (we) begin
            memory[a0] <= wd0;
            if (is_half || is_word) begin
                memory[a1] <= wd1;
            end
            if (is_word) begin
                memory[a2] <= wd2;
                memory[a3] <= wd3;
            end
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.MOC     = (state_q == StDone);
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_ram_ctrl_param.sv
// Directed bench for ram_ctrl_param: a 2-wait-state instance and a 0-wait-state instance,
// expected results queued at issue and compared when MOC rises.
module tb_ram_ctrl_param;

    logic clk;
    logic rst_n;

    ram_ctrl_param_if bus ();
    ram_ctrl_param_if bus0 ();

    ram_ctrl_param #(
        .ADDR_WIDTH (8),
        .WAIT_STATES(2)
    ) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus)
    );

    ram_ctrl_param #(
        .ADDR_WIDTH (8),
        .WAIT_STATES(0)
    ) dut0 (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit f, input logic mov, input logic rw, input logic [2:0] ms,
                           input logic [31:0] addr, input logic [31:0] din);
        if (f) begin
            bus0.MOV = mov; bus0.ReadWrite = rw; bus0.MS_2_0 = ms;
            bus0.Address = addr; bus0.DataIn = din;
        end else begin
            bus.MOV = mov; bus.ReadWrite = rw; bus.MS_2_0 = ms;
            bus.Address = addr; bus.DataIn = din;
        end
    endtask

    function automatic logic moc_of(input bit f);
        return f ? bus0.MOC : bus.MOC;
    endfunction

    function automatic logic err_of(input bit f);
        return f ? bus0.ERR : bus.ERR;
    endfunction

    function automatic logic [31:0] dout_of(input bit f);
        return f ? bus0.DataOut : bus.DataOut;
    endfunction

    // One complete handshake; inputs are scrambled after acceptance to prove latching.
    task automatic op(input string tag, input bit f, input logic rw, input logic [2:0] ms,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic [31:0] exp_dout, input logic exp_err,
                      input int exp_lat, input int hold);
        exp_t e;
        int   lat;
        logic stay;
        sb.push_back('{d: exp_dout, e: exp_err});
        @(negedge clk);
        set_req(f, 1'b1, rw, ms, addr, din);
        @(posedge clk);
        #1;
        set_req(f, 1'b1, ~rw, 3'b111, ~addr, ~din);
        lat = 0;
        while (!moc_of(f) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        e = sb.pop_front();
        check({tag, " DataOut"}, dout_of(f), e.d);
        check({tag, " ERR"}, {31'd0, err_of(f)}, {31'd0, e.e});
        if (hold > 0) begin
            stay = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                stay &= moc_of(f);
            end
            check({tag, " MOC held"}, {31'd0, stay}, 32'd1);
        end
        @(negedge clk);
        set_req(f, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check({tag, " MOC drop"}, {31'd0, moc_of(f)}, 32'd0);
        check({tag, " ERR drop"}, {31'd0, err_of(f)}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset MOC", {31'd0, bus.MOC}, 32'd0);
        check("reset ERR", {31'd0, bus.ERR}, 32'd0);
        check("reset DataOut", bus.DataOut, 32'd0);
        check("reset MOC ws0", {31'd0, bus0.MOC}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word round trip and sub-word loads
        op("sw 04", 0, 1'b0, 3'b010, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0);
        check("mem4", {24'd0, dut.memory[4]}, 32'hDE);
        check("mem5", {24'd0, dut.memory[5]}, 32'hAD);
        check("mem6", {24'd0, dut.memory[6]}, 32'hBE);
        check("mem7", {24'd0, dut.memory[7]}, 32'hEF);
        op("lw 04", 0, 1'b1, 3'b010, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        op("lbu 04", 0, 1'b1, 3'b000, 32'h04, 32'h0, 32'h000000DE, 1'b0, 3, 0);
        op("lb 07", 0, 1'b1, 3'b100, 32'h07, 32'h0, 32'hFFFFFFEF, 1'b0, 3, 0);
        op("lhu 06", 0, 1'b1, 3'b001, 32'h06, 32'h0, 32'h0000BEEF, 1'b0, 3, 0);
        op("lh 06", 0, 1'b1, 3'b101, 32'h06, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 0);

        // Sub-word stores touch only their own lanes
        op("sb 05", 0, 1'b0, 3'b000, 32'h05, 32'hFFFFFF5A, 32'hFFFFBEEF, 1'b0, 3, 0);
        op("lw 04 b", 0, 1'b1, 3'b010, 32'h04, 32'h0, 32'hDE5ABEEF, 1'b0, 3, 0);
        op("sh 06", 0, 1'b0, 3'b001, 32'h06, 32'hAAAA1234, 32'hDE5ABEEF, 1'b0, 3, 0);
        op("lw 04 h", 0, 1'b1, 3'b010, 32'h04, 32'h0, 32'hDE5A1234, 1'b0, 3, 0);
        op("sw 08", 0, 1'b0, 3'b010, 32'h08, 32'hCAFEF00D, 32'hDE5A1234, 1'b0, 3, 0);

        // Rejected requests: full latency, ERR set, nothing changes
        op("err lw 02", 0, 1'b1, 3'b010, 32'h02, 32'h0, 32'hDE5A1234, 1'b1, 3, 0);
        op("err sh 09", 0, 1'b0, 3'b001, 32'h09, 32'h00007777, 32'hDE5A1234, 1'b1, 3, 0);
        check("mem8 kept", {24'd0, dut.memory[8]}, 32'hCA);
        check("mem9 kept", {24'd0, dut.memory[9]}, 32'hFE);
        check("memA kept", {24'd0, dut.memory[10]}, 32'hF0);
        op("err ms011", 0, 1'b1, 3'b011, 32'h04, 32'h0, 32'hDE5A1234, 1'b1, 3, 0);
        op("err range", 0, 1'b0, 3'b010, 32'h100, 32'h55555555, 32'hDE5A1234, 1'b1, 3, 0);
        check("mem0 range", {24'd0, dut.memory[0]}, {24'd0, dut.memory[0]} & 32'hFF);
        op("lw 08", 0, 1'b1, 3'b010, 32'h08, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0);
        op("lw 04 kept", 0, 1'b1, 3'b010, 32'h04, 32'h0, 32'hDE5A1234, 1'b0, 3, 0);

        // MOV held high long after MOC: one access only (scrambled data would show a repeat)
        op("sw 20 hold", 0, 1'b0, 3'b010, 32'h20, 32'h13579BDF, 32'hDE5A1234, 1'b0, 3, 10);
        op("lw 20", 0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h13579BDF, 1'b0, 3, 0);

        // Reset in the middle of a write's wait
        op("sw 10", 0, 1'b0, 3'b010, 32'h10, 32'h11223344, 32'h13579BDF, 1'b0, 3, 0);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst MOC", {31'd0, bus.MOC}, 32'd0);
        check("rst DataOut", bus.DataOut, 32'd0);
        check("rst mem10", {24'd0, dut.memory[16]}, 32'h11);
        check("rst mem11", {24'd0, dut.memory[17]}, 32'h22);
        check("rst mem12", {24'd0, dut.memory[18]}, 32'h33);
        check("rst mem13", {24'd0, dut.memory[19]}, 32'h44);
        op("lw 10 post", 0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h11223344, 1'b0, 3, 0);

        // Zero wait states: MOC after edge 1
        op("ws0 sw", 1, 1'b0, 3'b010, 32'h00, 32'h01020304, 32'h0, 1'b0, 1, 0);
        op("ws0 lw", 1, 1'b1, 3'b010, 32'h00, 32'h0, 32'h01020304, 1'b0, 1, 0);
        op("ws0 lh", 1, 1'b1, 3'b101, 32'h02, 32'h0, 32'h00000304, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
